// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryption core: one round per clock with on-the-fly
// key expansion, valid/ready handshakes on the job input and the result output.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset is 8*(255-a).
    assign y_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module aes_enc_iter #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        plaintext,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ciphertext,
    output logic                busy
);
    localparam int unsigned NK   = KEY_BITS / 32;
    localparam int unsigned NR   = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0]  NR_L = 4'(NR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] p, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = p[127:96] ^ t;
        w1 = p[95:64]  ^ w0;
        w2 = p[63:32]  ^ w1;
        w3 = p[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         in_ready_q, out_valid_q, busy_q;
    logic         accept_c;

    logic [127:0] sb_c, sr_c, mc_c;
    logic [31:0]  kw_in_c, kw_sub_c, kw_t_c;
    logic [7:0]   rcon_use_c;
    logic         use_rot_c, rcon_adv_c;
    logic [127:0] kexp_c, rk_acc_c, rk_run_c;

    // Round datapath: SubBytes, ShiftRows, MixColumns on the current state.
    for (genvar k = 0; k < 16; k++) begin : g_sbox
        aes_sbox u_sbox (.a_i(st_q[127-8*k -: 8]), .y_o(sb_c[127-8*k -: 8]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_c[127-8*(4*c+r) -: 8] = sb_c[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc_c[127-32*c -: 32] = mix_col(sr_c[127-32*c -: 32]);
    end

    // Key path: one SubWord on the last key word; the accept edge expands straight from the key.
    for (genvar k = 0; k < 4; k++) begin : g_ksbox
        aes_sbox u_sbox (.a_i(kw_in_c[31-8*k -: 8]), .y_o(kw_sub_c[31-8*k -: 8]));
    end

    assign rcon_use_c = (fsm_q == S_IDLE) ? 8'h01 : xtime(rcon_q);
    assign kw_t_c     = use_rot_c ? ({kw_sub_c[23:0], kw_sub_c[31:24]} ^ {rcon_use_c, 24'h0})
                                  : kw_sub_c;
    assign kexp_c     = expand((fsm_q == S_IDLE) ? key[KEY_BITS-1 -: 128] : rk_q, kw_t_c);

    if (NK == 8) begin : g_k256
        logic [127:0] rk_nxt_q, rk_nxt_d;

        assign rk_nxt_d   = (accept_c || fsm_q == S_RUN) ? kexp_c : rk_nxt_q;
        assign kw_in_c    = (fsm_q == S_IDLE) ? key[31:0] : rk_nxt_q[31:0];
        assign use_rot_c  = (fsm_q == S_IDLE) || !round_q[0];
        assign rcon_adv_c = !round_q[0];
        assign rk_acc_c   = key[127:0];
        assign rk_run_c   = rk_nxt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rk_nxt_q <= '0;
            end else begin
                rk_nxt_q <= rk_nxt_d;
            end
        end
    end else begin : g_k128
        assign kw_in_c    = (fsm_q == S_IDLE) ? key[31:0] : rk_q[31:0];
        assign use_rot_c  = 1'b1;
        assign rcon_adv_c = 1'b1;
        assign rk_acc_c   = kexp_c;
        assign rk_run_c   = kexp_c;
    end

    always_comb begin
        fsm_d    = fsm_q;
        st_d     = st_q;
        rk_d     = rk_q;
        ct_d     = ct_q;
        rcon_d   = rcon_q;
        round_d  = round_q;
        accept_c = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept_c = 1'b1;
                    fsm_d    = S_RUN;
                    st_d     = plaintext ^ key[KEY_BITS-1 -: 128];
                    rk_d     = rk_acc_c;
                    rcon_d   = 8'h01;
                    round_d  = 4'd1;
                end
            end
            S_RUN: begin
                rk_d = rk_run_c;
                if (rcon_adv_c) begin
                    rcon_d = xtime(rcon_q);
                end
                if (round_q == NR_L) begin
                    ct_d  = sr_c ^ rk_q;
                    fsm_d = S_DONE;
                end else begin
                    st_d    = mc_c ^ rk_q;
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            ct_q        <= '0;
            rcon_q      <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            ct_q        <= ct_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            in_ready_q  <= (fsm_d == S_IDLE);
            out_valid_q <= (fsm_d == S_DONE);
            busy_q      <= (fsm_d == S_RUN);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ciphertext = ct_q;
endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: known-answer, backpressure, back-to-back, reset-abort
// and random jobs on a 128-bit and a 256-bit instance against a byte-level AES model.

module tb_aes_enc_iter;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] key_a, pt_a, ct_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [255:0] key_b;
    logic [127:0] pt_b, ct_b;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sbox_m [256];

    always #5 clk = ~clk;

    aes_enc_iter #(.KEY_BITS(128)) dut_128 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .key(key_a), .plaintext(pt_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .ciphertext(ct_a), .busy(busy_a)
    );

    aes_enc_iter #(.KEY_BITS(256)) dut_256 (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .key(key_b), .plaintext(pt_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .ciphertext(ct_b), .busy(busy_b)
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // FIPS-197 Cipher on a byte array; key left-aligned in k, nk words long
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
        logic [31:0] w [60];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8];
        for (int rnd = 0; rnd <= nr; rnd++) begin
            if (rnd > 0) begin
                for (int b = 0; b < 16; b++) t[b] = sbox_m[s[b]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
                if (rnd < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                tmp = w[4*rnd+c];
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ tmp[31-8*r -: 8];
            end
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input logic [255:0] k,
                         input logic [127:0] p, input logic ordy);
        if (sel) begin
            in_valid_b = v; key_b = k; pt_b = p; out_ready_b = ordy;
        end else begin
            in_valid_a = v; key_a = k[255:128]; pt_a = p; out_ready_a = ordy;
        end
    endtask

    task automatic sample(input bit sel, output logic ir, output logic ov,
                          output logic bz, output logic [127:0] ct);
        if (sel) begin
            ir = in_ready_b; ov = out_valid_b; bz = busy_b; ct = ct_b;
        end else begin
            ir = in_ready_a; ov = out_valid_a; bz = busy_a; ct = ct_a;
        end
    endtask

    // One job: accept, wait for the result, stall bp cycles, then hand it off.
    task automatic run_job(input bit sel, input logic [255:0] k, input logic [127:0] pt,
                           input logic [127:0] exp, input int bp, input bit hold, input string tag);
        int nr, lat;
        logic ir, ov, bz;
        logic [127:0] ct;
        nr = sel ? 14 : 10;
        drive(sel, 1'b1, k, pt, bp == 0);
        sample(sel, ir, ov, bz, ct);
        check({tag, " in_ready before accept"}, 128'(ir), 128'd1);
        tick();
        drive(sel, hold ? 1'b1 : 1'b0, rnd256(), rnd128(), bp == 0);
        sample(sel, ir, ov, bz, ct);
        check({tag, " busy/in_ready/out_valid after accept"}, 128'({bz, ir, ov}), 128'b100);
        lat = 0;
        do begin
            tick();
            lat++;
            drive(sel, hold ? 1'b1 : 1'($urandom_range(0, 1)), rnd256(), rnd128(), bp == 0);
            sample(sel, ir, ov, bz, ct);
        end while (!ov && lat < 40);
        check({tag, " latency"}, 128'(lat), 128'(nr));
        check({tag, " ciphertext"}, ct, exp);
        check({tag, " in_ready/busy in done"}, 128'({ir, bz}), 128'b00);
        for (int i = 0; i < bp; i++) begin
            tick();
            drive(sel, hold ? 1'b1 : 1'($urandom_range(0, 1)), rnd256(), rnd128(), i == bp - 1);
            sample(sel, ir, ov, bz, ct);
            check({tag, " stalled out_valid/in_ready"}, 128'({ov, ir}), 128'b10);
            check({tag, " stalled ciphertext"}, ct, exp);
        end
        tick();
        drive(sel, hold, rnd256(), rnd128(), 1'b0);
        sample(sel, ir, ov, bz, ct);
        check({tag, " after handoff out_valid/in_ready"}, 128'({ov, ir}), 128'b01);
        check({tag, " ciphertext held after handoff"}, ct, exp);
    endtask

    initial begin
        logic [7:0]   inv, b, s;
        logic         ir, ov, bz, ov_seen;
        logic [127:0] ct, pt;
        logic [255:0] k;
        bit           sel;
        int           bp;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = inv;
            for (int i = 0; i < 4; i++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sbox_m[x] = s ^ 8'h63;
        end

        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            sample(d[0], ir, ov, bz, ct);
            check("reset flags", 128'({ir, ov, bz}), 128'b000);
            check("reset ciphertext", ct, 128'h0);
        end
        reset = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            sample(d[0], ir, ov, bz, ct);
            check("post-reset in_ready/out_valid/busy", 128'({ir, ov, bz}), 128'b100);
        end

        run_job(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, "kat128_b");
        run_job(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, "kat128_c1");
        run_job(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff,
                128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0, "kat256_c3");
        run_job(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 20, 1'b0, "backpressure");
        run_job(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b1, "b2b_first");
        run_job(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, "b2b_second");

        for (int j = 0; j < 8; j++) begin
            sel = 1'($urandom_range(0, 1));
            k   = sel ? rnd256() : {rnd128(), 128'h0};
            pt  = rnd128();
            bp  = $urandom_range(0, 3);
            run_job(sel, k, pt, aes_ref(k, sel ? 8 : 4, pt), bp, 1'b0, "random");
        end

        // Abort a job mid-flight with an asynchronous reset.
        drive(1'b0, 1'b1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h00112233445566778899aabbccddeeff, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        sample(1'b0, ir, ov, bz, ct);
        check("abort flags", 128'({ir, ov, bz}), 128'b000);
        check("abort ciphertext", ct, 128'h0);
        tick();
        tick();
        reset = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sample(1'b0, ir, ov, bz, ct);
            ov_seen = ov_seen | ov | bz;
        end
        check("no activity from aborted job", 128'(ov_seen), 128'd0);
        run_job(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
